// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data memory between the core pipeline and one
//   external requester (loader / DMA / NIC). The core always wins, because
//   the pipeline cannot stall on memory. External requests wait in a small
//   FIFO and issue in cycles when the core leaves the memory idle. A
//   starvation counter raises an advisory stall request back to the core.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   core_*              pipeline dmem interface (enable, store, addr, wdata,
//                       rdata) and the advisory core_stall_req
//   ext_req_*           external request channel (valid/ready, we, addr,
//                       wdata)
//   ext_rsp_*           external read response (one-cycle valid, data)
//   ext_busy            FIFO non-empty or a read response still owed
//   dmem_*              DMEM macro interface; read data arrives the cycle
//                       after the read is issued
//   stat_*_cnt          statistics counters
//
// Build option
//   DMEM_ARB_STATS_EN   when defined, stat_core_cnt / stat_ext_cnt /
//                       stat_conflict_cnt are live 32-bit wrapping counters;
//                       otherwise the ports are tied to 0.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_mem_en,
  input  logic                  core_store_en,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_stall_req,
  input  logic                  ext_req_valid,
  output logic                  ext_req_ready,
  input  logic                  ext_req_we,
  input  logic [ADDR_WIDTH-1:0] ext_req_addr,
  input  logic [DATA_WIDTH-1:0] ext_req_wdata,
  output logic                  ext_rsp_valid,
  output logic [DATA_WIDTH-1:0] ext_rsp_rdata,
  output logic                  ext_busy,
  output logic                  dmem_mem_en,
  output logic                  dmem_store_en,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [31:0]           stat_core_cnt,
  output logic [31:0]           stat_ext_cnt,
  output logic [31:0]           stat_conflict_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  // FIFO storage (data only, never reset) and control state
  logic                  r_fifo_we    [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_fifo_addr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_wdata [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic                  r_pend;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [STV_W-1:0]      r_starve;
  logic                  r_stall;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_ext_issue;
  logic                  w_head_we;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_wdata;
  logic [STV_W-1:0]      w_starve_nxt;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  // Ready looks only at the registered count, so a same-cycle pop never
  // opens a slot for a request presented against a full FIFO.
  assign w_push       = ext_req_valid && !w_full;
  assign w_ext_issue  = !core_mem_en && !w_empty;
  assign w_head_we    = r_fifo_we[r_rptr];
  assign w_head_addr  = r_fifo_addr[r_rptr];
  assign w_head_wdata = r_fifo_wdata[r_rptr];

  assign ext_req_ready  = !w_full;
  assign ext_busy       = !w_empty || r_pend;
  assign core_rdata     = dmem_rdata;
  assign core_stall_req = r_stall;
  assign ext_rsp_valid  = r_pend;
  // During the response cycle the DMEM read data is forwarded; afterwards
  // the captured copy is held so the value stays stable for the requester.
  assign ext_rsp_rdata  = r_pend ? dmem_rdata : r_rsp_rdata;

  // ---- issue: core first, then FIFO head ----
  always_comb begin
    dmem_mem_en   = 1'b0;
    dmem_store_en = 1'b0;
    dmem_addr     = '0;
    dmem_wdata    = '0;
    if (core_mem_en) begin
      dmem_mem_en   = 1'b1;
      dmem_store_en = core_store_en;
      dmem_addr     = core_addr;
      dmem_wdata    = core_store_en ? core_wdata : '0;
    end else if (!w_empty) begin
      dmem_mem_en   = 1'b1;
      dmem_store_en = w_head_we;
      dmem_addr     = w_head_addr;
      dmem_wdata    = w_head_we ? w_head_wdata : '0;
    end
  end

  // Blocked cycles only accumulate while the core holds the memory and
  // something is waiting; any idle-core cycle with a non-empty FIFO is an
  // external issue, and an empty FIFO has nothing to starve.
  always_comb begin
    w_starve_nxt = '0;
    if (core_mem_en && !w_empty) begin
      if (r_starve == STV_W'(STARVE_LIMIT)) w_starve_nxt = r_starve;
      else                                  w_starve_nxt = r_starve + 1'b1;
    end
  end

  // ---- FIFO write port ----
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_fifo_we[r_wptr]    <= ext_req_we;
      r_fifo_addr[r_wptr]  <= ext_req_addr;
      r_fifo_wdata[r_wptr] <= ext_req_wdata;
    end
  end

  // ---- control state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_pend      <= 1'b0;
      r_rsp_rdata <= '0;
      r_starve    <= '0;
      r_stall     <= 1'b0;
    end else begin
      if (w_push)      r_wptr <= r_wptr + 1'b1;
      if (w_ext_issue) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_ext_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_pend <= w_ext_issue && !w_head_we;
      if (r_pend) r_rsp_rdata <= dmem_rdata;
      r_starve <= w_starve_nxt;
      r_stall  <= (w_starve_nxt == STV_W'(STARVE_LIMIT));
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_stat_core;
  logic [31:0] r_stat_ext;
  logic [31:0] r_stat_conflict;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_core     <= '0;
      r_stat_ext      <= '0;
      r_stat_conflict <= '0;
    end else begin
      if (core_mem_en)             r_stat_core     <= r_stat_core + 32'd1;
      if (w_ext_issue)             r_stat_ext      <= r_stat_ext + 32'd1;
      if (core_mem_en && !w_empty) r_stat_conflict <= r_stat_conflict + 32'd1;
    end
  end

  assign stat_core_cnt     = r_stat_core;
  assign stat_ext_cnt      = r_stat_ext;
  assign stat_conflict_cnt = r_stat_conflict;
`else
  assign stat_core_cnt     = '0;
  assign stat_ext_cnt      = '0;
  assign stat_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Randomized and directed stimulus for dmem_arbiter against a queue-based
//   reference model. Accepted external requests and expected read data are
//   queued as they are predicted; independent monitors pop them when the DUT
//   issues to DMEM or presents a response.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_mem_en, core_store_en;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          core_stall_req;
  logic          ext_req_valid, ext_req_ready, ext_req_we;
  logic [AW-1:0] ext_req_addr;
  logic [DW-1:0] ext_req_wdata;
  logic          ext_rsp_valid;
  logic [DW-1:0] ext_rsp_rdata;
  logic          ext_busy;
  logic          dmem_mem_en, dmem_store_en;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic [31:0]   stat_core_cnt, stat_ext_cnt, stat_conflict_cnt;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH),
                 .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .core_mem_en(core_mem_en), .core_store_en(core_store_en),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_stall_req(core_stall_req),
    .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready),
    .ext_req_we(ext_req_we), .ext_req_addr(ext_req_addr),
    .ext_req_wdata(ext_req_wdata),
    .ext_rsp_valid(ext_rsp_valid), .ext_rsp_rdata(ext_rsp_rdata),
    .ext_busy(ext_busy),
    .dmem_mem_en(dmem_mem_en), .dmem_store_en(dmem_store_en),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .stat_core_cnt(stat_core_cnt), .stat_ext_cnt(stat_ext_cnt),
    .stat_conflict_cnt(stat_conflict_cnt)
  );

  // Synchronous DMEM model, 16 words, driven only by the DUT's DMEM port
  logic          mem_clr;
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      dmem_rdata <= '0;
    end else if (dmem_mem_en) begin
      if (dmem_store_en) mem[dmem_addr[3:0]] <= dmem_wdata;
      else               dmem_rdata <= mem[dmem_addr[3:0]];
    end
  end

  // Reference model state
  req_t          mq[$];
  req_t          exp_issue[$];
  logic [DW-1:0] rsp_q[$];
  logic [DW-1:0] ref_mem [16];
  bit            m_pend, m_stall;
  int            m_starve;
  logic [31:0]   m_sc, m_se, m_scf;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input logic [63:0] act,
                              input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Response monitor
  always @(negedge clk) begin
    if (ext_rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected: actual=1 required=0 (t=%0t)", $time);
      end else begin
        chk("ext_rsp_rdata", ext_rsp_rdata, rsp_q.pop_front());
      end
    end
  end

  // External-issue monitor: order and content of FIFO issues
  always @(negedge clk) begin
    req_t h;
    if (dmem_mem_en === 1'b1 && core_mem_en === 1'b0) begin
      if (exp_issue.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL issue_unexpected: actual addr=%0h required none (t=%0t)",
                 dmem_addr, $time);
      end else begin
        h = exp_issue.pop_front();
        chk("issue_addr", dmem_addr, h.addr);
        chk("issue_we", dmem_store_en, h.we);
        chk("issue_wdata", dmem_wdata, h.we ? h.wdata : '0);
      end
    end
  end

  // One cycle: drive at posedge+1, check at negedge, advance model after.
  task automatic step(input logic r, input logic ce, input logic cs,
                      input logic [AW-1:0] ca, input logic [DW-1:0] cw,
                      input logic ev, input logic ew,
                      input logic [AW-1:0] ea, input logic [DW-1:0] ewd,
                      output bit acc);
    bit            issue;
    int            pre;
    req_t          h, nr;
    logic          x_en, x_st;
    logic [AW-1:0] x_a;
    logic [DW-1:0] x_w;
    rst = r; core_mem_en = ce; core_store_en = cs; core_addr = ca;
    core_wdata = cw; ext_req_valid = ev; ext_req_we = ew;
    ext_req_addr = ea; ext_req_wdata = ewd;
    nr = '{we: ew, addr: ea, wdata: ewd};
    pre   = mq.size();
    issue = !ce && pre > 0;
    h     = issue ? mq[0] : '0;
    x_en = 1'b0; x_st = 1'b0; x_a = '0; x_w = '0;
    if (ce) begin
      x_en = 1'b1; x_st = cs; x_a = ca; x_w = cs ? cw : '0;
    end else if (issue) begin
      x_en = 1'b1; x_st = h.we; x_a = h.addr; x_w = h.we ? h.wdata : '0;
    end
    @(negedge clk);
    chk("dmem_mem_en", dmem_mem_en, x_en);
    chk("dmem_store_en", dmem_store_en, x_st);
    chk("dmem_addr", dmem_addr, x_a);
    chk("dmem_wdata", dmem_wdata, x_w);
    chk("ext_req_ready", ext_req_ready, pre < DEPTH);
    chk("ext_busy", ext_busy, (pre > 0) || m_pend);
    chk("ext_rsp_valid", ext_rsp_valid, m_pend);
    chk("core_stall_req", core_stall_req, m_stall);
    chk("core_rdata", core_rdata, dmem_rdata);
`ifdef DMEM_ARB_STATS_EN
    chk("stat_core_cnt", stat_core_cnt, m_sc);
    chk("stat_ext_cnt", stat_ext_cnt, m_se);
    chk("stat_conflict_cnt", stat_conflict_cnt, m_scf);
`else
    chk("stat_core_cnt", stat_core_cnt, 0);
    chk("stat_ext_cnt", stat_ext_cnt, 0);
    chk("stat_conflict_cnt", stat_conflict_cnt, 0);
`endif
    #1;
    if (ce && cs) ref_mem[ca[3:0]] = cw;
    if (issue) begin
      if (h.we) ref_mem[h.addr[3:0]] = h.wdata;
      else      rsp_q.push_back(ref_mem[h.addr[3:0]]);
    end
    acc = 1'b0;
    if (r) begin
      mq.delete(); exp_issue.delete(); rsp_q.delete();
      m_pend = 0; m_stall = 0; m_starve = 0;
      m_sc = '0; m_se = '0; m_scf = '0;
    end else begin
      if (ce)            m_sc  = m_sc + 1;
      if (issue)         m_se  = m_se + 1;
      if (ce && pre > 0) m_scf = m_scf + 1;
      m_pend = issue && !h.we;
      if (ce && pre > 0) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else               m_starve = 0;
      m_stall = (m_starve == LIMIT);
      acc = ev && (pre < DEPTH);
      if (issue) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(nr);
        exp_issue.push_back(nr);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, '0, '0, a);
  endtask

  initial begin
    bit acc;
    int busy_pct;
    int tries;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    m_pend = 0; m_stall = 0; m_starve = 0; m_sc = '0; m_se = '0; m_scf = '0;
    mem_clr = 1'b1; rst = 1'b1;
    core_mem_en = 0; core_store_en = 0; core_addr = '0; core_wdata = '0;
    ext_req_valid = 0; ext_req_we = 0; ext_req_addr = '0; ext_req_wdata = '0;
    repeat (2) @(posedge clk);
    mem_clr = 1'b0;
    @(negedge clk);
    chk("rst_ready", ext_req_ready, 1'b1);
    chk("rst_busy", ext_busy, 1'b0);
    chk("rst_rsp_valid", ext_rsp_valid, 1'b0);
    chk("rst_rsp_rdata", ext_rsp_rdata, '0);
    chk("rst_stall", core_stall_req, 1'b0);
    chk("rst_dmem_en", dmem_mem_en, 1'b0);
    chk("rst_dmem_addr", dmem_addr, '0);
    @(posedge clk);
    #1;

    // External write with idle core, then read it back
    step(0, 0, 0, '0, '0, 1, 1, 32'h10, 64'hAA, acc);
    idle(3);
    step(0, 0, 0, '0, '0, 1, 0, 32'h10, '0, acc);
    idle(3);

    // Starvation: read queued, then core busy for 12 cycles
    step(1, 0, 0, '0, '0, 0, 0, '0, '0, acc);
    step(0, 0, 0, '0, '0, 1, 0, 32'h10, '0, acc);
    for (int i = 0; i < 12; i++)
      step(0, 1, i[0], 32'h20 + i, 64'h100 + i, 0, 0, '0, '0, acc);
    idle(4);

    // Five back-to-back pushes against a busy core
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 32'h3, '0, 1, i[0], 32'h4 + i, 64'h5500 + i, acc);
    acc = 0;
    tries = 0;
    while (!acc && tries < 10) begin
      step(0, (tries < 2), 0, 32'h3, '0, 1, 0, 32'h9, '0, acc);
      tries++;
    end
    chk("fifth_accepted", acc, 1'b1);
    idle(6);

    // Reset with queued requests and a read in flight
    step(0, 1, 0, 32'h1, '0, 1, 0, 32'h4, '0, acc);
    step(0, 1, 0, 32'h1, '0, 1, 1, 32'h6, 64'h77, acc);
    step(0, 1, 0, 32'h1, '0, 1, 0, 32'h5, '0, acc);
    step(0, 1, 0, 32'h1, '0, 1, 0, 32'h7, '0, acc);
    step(0, 0, 0, '0, '0, 0, 0, '0, '0, acc);
    step(1, 0, 0, '0, '0, 1, 0, 32'h8, '0, acc);
    idle(4);

    // Randomized traffic with occasional resets and busy-core bursts
    busy_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) busy_pct = ($urandom_range(0, 3) == 0) ? 97 : 55;
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < busy_pct), $urandom_range(0, 1),
           AW'($urandom_range(0, 15)), {$urandom, $urandom},
           $urandom_range(0, 1), $urandom_range(0, 1),
           AW'($urandom_range(0, 15)), {$urandom, $urandom}, acc);
    end
    idle(12);
    chk("drain_rsp_q", rsp_q.size(), 0);
    chk("drain_issue_q", exp_issue.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the 4-stage core pipeline and one external requester, such as a loader, DMA or NIC.
- Sits between the pipeline's dmem interface (mem enable, store enable, address, write data, read data) and the DMEM macro.
- The core has absolute priority because the pipeline cannot stall on memory.
- External requests are buffered in a small FIFO and issued in cycles when the core is idle.
- A starvation counter raises an advisory stall request to the core.

Parameters:
- DATA_WIDTH, 64, width of memory data words.
- ADDR_WIDTH, 32, width of memory addresses.
- FIFO_DEPTH, 4, external request FIFO entries; must be a power of 2, minimum 2.
- STARVE_LIMIT, 8, number of consecutive blocked cycles of a non-empty FIFO before core_stall_req asserts.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- core_mem_en  input  1  core requests a DMEM access this cycle.
- core_store_en  input  1  core access is a write; valid only with core_mem_en.
- core_addr  input  ADDR_WIDTH  core address.
- core_wdata  input  DATA_WIDTH  core write data.
- core_rdata  output  DATA_WIDTH  read data to core; equals dmem_rdata.
- core_stall_req  output  1  advisory: the external requester is starving.
- ext_req_valid  input  1  external request present.
- ext_req_ready  output  1  FIFO can accept a request.
- ext_req_we  input  1  external request is a write.
- ext_req_addr  input  ADDR_WIDTH  external address.
- ext_req_wdata  input  DATA_WIDTH  external write data.
- ext_rsp_valid  output  1  one-cycle pulse: external read data valid.
- ext_rsp_rdata  output  DATA_WIDTH  external read data.
- ext_busy  output  1  FIFO non-empty or a read response is pending.
- dmem_mem_en  output  1  DMEM enable.
- dmem_store_en  output  1  DMEM write enable.
- dmem_addr  output  ADDR_WIDTH  DMEM address.
- dmem_wdata  output  DATA_WIDTH  DMEM write data.
- dmem_rdata  input  DATA_WIDTH  DMEM read data; synchronous, valid the cycle after the read is issued.
- stat_core_cnt, stat_ext_cnt, stat_conflict_cnt  output  32 each  statistics counters (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - FIFO empty; ext_req_ready=1; ext_rsp_valid=0; ext_rsp_rdata=0; ext_busy=0; core_stall_req=0.
  - Starve counter 0; read-pending flag 0; stat counters 0.
  - DMEM outputs follow the combinational issue rule below; with core_mem_en=0 and an empty FIFO they are all 0.
- FIFO accept:
  - ext_req_ready = !full, computed from the registered count only.
  - A push occurs when ext_req_valid && ext_req_ready.
  - When full, the request is refused even if a pop happens in the same cycle.
  - No bypass: an entry pushed in cycle N is issuable from cycle N+1 at the earliest.
- Issue rule (combinational, per cycle):
  - If core_mem_en=1: DMEM is driven by core_store_en, core_addr and core_wdata, with dmem_mem_en=1.
  - Else if the FIFO is non-empty: DMEM is driven by the head entry, dmem_mem_en=1, dmem_store_en=head.we, and the FIFO pops at the clock edge.
  - Else: all DMEM outputs are 0.
  - Write data to DMEM is 0 for reads.
- Responses:
  - An external read issued in cycle N sets the pending flag.
  - In cycle N+1: ext_rsp_valid=1 and ext_rsp_rdata=dmem_rdata. ext_rsp_rdata is registered, holds its value and is sampled by the requester on that pulse.
  - External writes produce no response.
  - Core reads need no arbiter state; core_rdata is wired directly to dmem_rdata.
  - Back-to-back external reads give back-to-back pulses in request order.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and core_mem_en=1.
  - It clears on any external issue, or when the FIFO becomes empty.
  - It saturates at STARVE_LIMIT.
  - core_stall_req is registered; it is 1 while counter == STARVE_LIMIT and drops the cycle after the next external issue.
  - The arbiter never overrides the core, even while core_stall_req=1.
- ext_busy = FIFO non-empty || pending flag.
- Reset mid-operation:
  - FIFO contents and the pending read are discarded; no ext_rsp_valid pulse follows the reset.
  - A push presented in the reset cycle is dropped.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: three 32-bit wrapping counters.
  - stat_core_cnt: +1 per cycle core_mem_en=1.
  - stat_ext_cnt: +1 per external issue.
  - stat_conflict_cnt: +1 per cycle core_mem_en=1 while the FIFO is non-empty.
  - All three clear on rst.
- Undefined: all three ports present but tied to constant 0; no counter logic is synthesised.

Test Plan:
1. Idle core; external write (we=1, addr=0x10, wdata=0xAA) in cycle 0 → dmem_mem_en=1, dmem_store_en=1, addr 0x10 in cycle 1; no ext_rsp_valid; ext_busy returns to 0 in cycle 2.
2. External read of addr 0x10 with dmem_rdata model returning 0xAA → issued in cycle 1, ext_rsp_valid single pulse in cycle 2 with ext_rsp_rdata=0xAA.
3. core_mem_en=1 for 12 cycles while one external read is queued → DMEM shows only the core address for all 12 cycles; core_stall_req rises after 8 blocked cycles (STARVE_LIMIT=8); the external read issues in the first core-idle cycle; core_stall_req falls one cycle later.
4. Push 5 requests back-to-back with the core busy → ext_req_ready=0 after 4 accepts; the 5th is held until a pop frees a slot; issue order matches push order.
5. Assert rst with 3 queued requests and a read pending → next cycle FIFO empty, ext_req_ready=1, no ext_rsp_valid pulse, no further dmem_mem_en from the external side.
6. With DMEM_ARB_STATS_EN defined, run scenario 3 → stat_core_cnt=12, stat_ext_cnt=1, stat_conflict_cnt=12. Undefined → all three read 0.
